serial_nibble_rx: RTL and testbench



---
 rtl/serial_nibble_rx_if.sv | 26 ++
 rtl/serial_nibble_rx.sv | 121 ++++++++++++
 tb/tb_serial_nibble_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_nibble_rx_if.sv
// Serial receiver bus: line input plus the decoded nibble, status pulses and counters.
interface serial_nibble_rx_if #(
  parameter int unsigned NDATA = 4,
  parameter int unsigned NCNT  = 4
);
  logic             serial_in;
  logic [NDATA-1:0] data_out;
  logic             valid;
  logic             parity_err;
  logic             frame_err;
  logic             busy;
  logic [NCNT-1:0]  frame_count;
  logic [NCNT-1:0]  err_count;

  // Line driver / result consumer side
  modport master (
    output serial_in,
    input  data_out, valid, parity_err, frame_err, busy, frame_count, err_count
  );

  // Receiver side
  modport slave (
    input  serial_in,
    output data_out, valid, parity_err, frame_err, busy, frame_count, err_count
  );
endinterface

// File: rtl/serial_nibble_rx.sv
// Framed nibble receiver: start(0), NDATA data bits LSB-first, even parity, stop(1).
// One bit sampled per clk_2 edge; all outputs registered.
module serial_nibble_rx #(
  parameter int unsigned NDATA = 4,
  parameter int unsigned NCNT  = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  serial_nibble_rx_if.slave bus
);

  localparam int unsigned CW = (NDATA > 1) ? $clog2(NDATA) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    HUNT   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [NDATA-1:0] r_shift;
  logic             r_par;
  logic [NDATA-1:0] r_data_out;
  logic             r_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic             r_busy;
  logic [NCNT-1:0]  r_frame_count;
  logic [NCNT-1:0]  r_err_count;

  logic             w_par_ok;
  logic [NCNT-1:0]  w_err_next;

  // Even parity across data and parity bit; error counter saturates at all-ones
  assign w_par_ok   = ~(^{r_shift, r_par});
  assign w_err_next = (r_err_count == {NCNT{1'b1}}) ? r_err_count : r_err_count + NCNT'(1);

  // Receiver FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_data_out    <= '0;
      r_valid       <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.serial_in) begin
            r_state <= DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        DATA: begin
          r_shift[r_cnt] <= bus.serial_in;
          if (r_cnt == CW'(NDATA - 1)) begin
            r_state <= PARITY;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
          r_par   <= bus.serial_in;
          r_state <= STOP;
        end
        STOP: begin
          if (bus.serial_in) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_par_ok) begin
              r_data_out    <= r_shift;
              r_valid       <= 1'b1;
              r_frame_count <= r_frame_count + NCNT'(1);
            end else begin
              r_parity_err <= 1'b1;
              r_err_count  <= w_err_next;
            end
          end else begin
            // Bad stop bit: wait for the line to return high before re-arming
            r_state      <= HUNT;
            r_frame_err  <= 1'b1;
            r_parity_err <= ~w_par_ok;
            r_err_count  <= w_err_next;
          end
        end
        HUNT: begin
          if (bus.serial_in) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid       = r_valid;
  assign bus.parity_err  = r_parity_err;
  assign bus.frame_err   = r_frame_err;
  assign bus.busy        = r_busy;
  assign bus.frame_count = r_frame_count;
  assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Bench for serial_nibble_rx: directed test-plan frames plus random frames,
// checked against a frame-level reference model.
module tb_serial_nibble_rx;

  localparam int unsigned NDATA = 4;
  localparam int unsigned NCNT  = 4;

  logic clk_2;
  logic reset;

  serial_nibble_rx_if #(.NDATA(NDATA), .NCNT(NCNT)) bus ();

  serial_nibble_rx #(.NDATA(NDATA), .NCNT(NCNT)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: last good nibble, counters, and whether the receiver hunts
  int m_data  = 0;
  int m_fcnt  = 0;
  int m_ecnt  = 0;
  bit m_hunt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit e_valid, input bit e_perr,
                           input bit e_ferr, input bit e_busy);
    check({tag, ".valid"},       32'(bus.valid),       32'(e_valid));
    check({tag, ".parity_err"},  32'(bus.parity_err),  32'(e_perr));
    check({tag, ".frame_err"},   32'(bus.frame_err),   32'(e_ferr));
    check({tag, ".busy"},        32'(bus.busy),        32'(e_busy));
    check({tag, ".data_out"},    32'(bus.data_out),    32'(m_data));
    check({tag, ".frame_count"}, 32'(bus.frame_count), 32'(m_fcnt));
    check({tag, ".err_count"},   32'(bus.err_count),   32'(m_ecnt));
  endtask

  // Drive one line bit at the falling edge, then look at the result 1 time unit after the rising edge
  task automatic drive_bit(input logic b);
    @(negedge clk_2);
    bus.serial_in = b;
    @(posedge clk_2);
    #1;
  endtask

  // Line-idle (or hunting) cycle: no start is possible here
  task automatic line_cycle(input logic b, input string tag);
    drive_bit(b);
    if (m_hunt && b) m_hunt = 0;
    check_all(tag, 1'b0, 1'b0, 1'b0, m_hunt);
  endtask

  // Send a whole frame; parity is forced wrong when par_bad is set
  task automatic send_frame(input logic [3:0] d, input bit par_bad, input logic stop, input string tag);
    logic [6:0] bits;
    logic       par;
    int         ones;
    bit         ok;
    par  = (^d) ^ par_bad;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_bit(bits[i]);
      if (i < 6) begin
        check_all(tag, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
    ones = $countones({d, par});
    ok   = (ones % 2) == 0;
    if (stop && ok) begin
      m_data = int'(d);
      m_fcnt = (m_fcnt + 1) % 16;
    end else begin
      m_ecnt = (m_ecnt < 15) ? m_ecnt + 1 : 15;
    end
    m_hunt = !stop;
    check_all(tag, stop && ok, !ok, !stop, !stop);
  endtask

  initial begin
    logic [3:0] rd;
    int         kind;
    reset = 1'b1;
    bus.serial_in = 1'b1;
    repeat (2) @(posedge clk_2);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_2);
    reset = 1'b0;

    // Good frame 0xA after two idle cycles
    line_cycle(1'b1, "idle0");
    line_cycle(1'b1, "idle1");
    send_frame(4'hA, 0, 1'b1, "good_a");
    line_cycle(1'b1, "after_a");

    // Back-to-back 0xB (parity 1) and 0x3 (parity 0)
    send_frame(4'hB, 0, 1'b1, "b2b_b");
    send_frame(4'h3, 0, 1'b1, "b2b_3");
    line_cycle(1'b1, "after_b2b");

    // Parity error
    send_frame(4'hB, 1, 1'b1, "perr_b");
    line_cycle(1'b1, "after_perr");

    // Framing error, low line held while hunting, then a good 0x6
    send_frame(4'h5, 0, 1'b0, "ferr_5");
    line_cycle(1'b0, "hunt0");
    line_cycle(1'b0, "hunt1");
    line_cycle(1'b0, "hunt2");
    line_cycle(1'b1, "hunt_exit");
    send_frame(4'h6, 0, 1'b1, "good_6");

    // Reset during the second data bit (0x9 = 1,0,0,1)
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(negedge clk_2);
    bus.serial_in = 1'b0;
    reset = 1'b1;
    @(posedge clk_2);
    #1;
    m_data = 0; m_fcnt = 0; m_ecnt = 0; m_hunt = 0;
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_2);
    reset = 1'b0;
    bus.serial_in = 1'b1;
    @(posedge clk_2);
    #1;
    check_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'h9, 0, 1'b1, "good_9");

    // 16 good frames back-to-back: frame_count wraps on the 16th valid
    for (int i = 0; i < 16; i++) begin
      rd = 4'($urandom_range(0, 15));
      send_frame(rd, 0, 1'b1, "wrap");
    end
    // 17 bad-parity frames: err_count saturates
    for (int i = 0; i < 17; i++) begin
      rd = 4'($urandom_range(0, 15));
      send_frame(rd, 1, 1'b1, "sat");
    end
    line_cycle(1'b1, "after_sat");

    // Random mix of good, parity-bad and stop-bad frames with random gaps
    reset = 1'b1;
    @(posedge clk_2);
    #1;
    m_data = 0; m_fcnt = 0; m_ecnt = 0; m_hunt = 0;
    @(negedge clk_2);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rd   = 4'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 3));
      send_frame(rd, kind == 2, kind != 3, "rand");
      if (m_hunt) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) line_cycle(1'b0, "rand_hunt");
        line_cycle(1'b1, "rand_rearm");
      end else begin
        for (int j = 0; j < int'($urandom_range(0, 1)); j++) line_cycle(1'b1, "rand_gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
